// File: rtl/rf_wb_arb.sv
// rf_wb_arb -- register-file write-back arbiter.
//
// Merges two result streams into a single register-file write port:
//   - port A: single-cycle (ALU) results, no buffering, normally wins;
//   - port B: long-latency (load/div) results, buffered in a 2-entry FIFO.
// A 2-bit starvation counter forces the FIFO head through after three
// consecutive A wins while B is waiting. The selected entry is registered,
// so every accepted result reaches wen/waddr/wdata exactly one cycle later.
// Writes to x0 are consumed but never raise wen.
//
// Optional feature (macro RF_WB_SCOREBOARD_EN):
//   defined   -> pend_mask tracks outstanding destination registers
//                (set on issue, cleared on the commit edge, set wins)
//   undefined -> pend_mask is constant 0 and iss_valid/iss_addr are ignored
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   a_valid/a_ready/a_addr/a_data  port A result handshake
//   b_valid/b_ready/b_addr/b_data  port B result handshake (FIFO side)
//   iss_valid/iss_addr          instruction issue with destination register
//   wen/waddr/wdata             registered register-file write port
//   pend_mask                   bit i set = write to x[i] outstanding

module rf_wb_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  output logic        wen,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [31:0] pend_mask
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  // B-side FIFO
  wb_entry_t  fifo_q [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       fifo_empty, fifo_full;

  // arbitration
  logic [1:0] starve_q, starve_d;
  logic       a_win, push, pop, load;
  wb_entry_t  a_entry, b_head, sel_entry;

  // output stage
  logic        wen_q, wen_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  assign fifo_empty = (cnt_q == 2'd0);
  assign fifo_full  = (cnt_q == 2'd2);

  assign a_entry = {a_addr, a_data};
  assign b_head  = fifo_q[rd_ptr_q];

  always_comb begin
    a_ready   = !((starve_q == 2'd3) && !fifo_empty);
    b_ready   = !fifo_full;
    a_win     = a_valid && a_ready;
    push      = b_valid && b_ready;
    // The FIFO head goes whenever A does not take the slot; when a_ready is
    // low A cannot win, so this is also the forced anti-starvation pop.
    pop       = !a_win && !fifo_empty;
    load      = a_win || pop;
    sel_entry = a_win ? a_entry : b_head;
  end

  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (push) wr_ptr_d = !wr_ptr_q;
    if (pop)  rd_ptr_d = !rd_ptr_q;
  end

  // Counter only runs while B is actually waiting behind A. It cannot pass 3:
  // at 3 with a non-empty FIFO a_ready is low, so A cannot win.
  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty)
      starve_d = 2'd0;
    else if (a_win)
      starve_d = starve_q + 2'd1;
  end

  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (load) begin
      wen_d   = (sel_entry.addr != 5'd0);
      waddr_d = sel_entry.addr;
      wdata_d = sel_entry.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      starve_q  <= 2'd0;
      wen_q     <= 1'b0;
      waddr_q   <= 5'd0;
      wdata_q   <= 32'd0;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= {b_addr, b_data};
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

`ifdef RF_WB_SCOREBOARD_EN
  logic [31:0] pend_q, pend_d;

  // Clear uses the registered write port, i.e. the edge on which the
  // register file actually commits. The set is applied last so a same-edge
  // re-issue of the register keeps it pending.
  always_comb begin
    pend_d = pend_q;
    if (wen_q)
      pend_d[waddr_q] = 1'b0;
    if (iss_valid && (iss_addr != 5'd0))
      pend_d[iss_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pend_q <= 32'd0;
    else
      pend_q <= pend_d;
  end

  assign pend_mask = pend_q;
`else
  logic unused_iss;
  assign unused_iss = ^{iss_valid, iss_addr};
  assign pend_mask  = 32'd0;
`endif

endmodule
